// File: rtl/counter_phase_tracker_pkg.sv
// ---------------------------------------------------------------------------
// counter_phase_tracker_pkg
// Shared definitions for the phase tracker and the upstream counter's bench.
//   phase_t    : tracker state encoding, also driven out on phase_o
//   DEF_X_MAX  : default value at which x stops ramping
//   DEF_Y_MAX  : default final y value of a period
// ---------------------------------------------------------------------------
package counter_phase_tracker_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        X_RAMP = 3'd1,
        Y_RAMP = 3'd2,
        WRAP   = 3'd3,
        ERROR  = 3'd4
    } phase_t;

    localparam int unsigned DEF_X_MAX = 8;
    localparam int unsigned DEF_Y_MAX = 6;

endpackage

// File: rtl/counter_phase_tracker_sat_counter8.sv
// ---------------------------------------------------------------------------
// sat_counter8
// 8-bit up counter with increment enable that sticks at 255 and clears
// synchronously.
//   clk   : clock, rising edge
//   clr   : synchronous clear, dominates inc
//   inc   : count up by one when not already at 255
//   count : current count
// ---------------------------------------------------------------------------
module sat_counter8 (
    input  logic       clk,
    input  logic       clr,
    input  logic       inc,
    output logic [7:0] count
);

    // Clear wins over increment; once at 255 further increments are ignored
    // so the count never wraps back to zero.
    always_ff @(posedge clk) begin
        if (clr) begin
            count <= 8'd0;
        end else if (inc && (count != 8'hFF)) begin
            count <= count + 8'd1;
        end
    end

endmodule

// File: rtl/counter_phase_tracker.sv
// ---------------------------------------------------------------------------
// counter_phase_tracker
// Watches an upstream {x,y} counter and checks that every period follows
// {0,0}, {1,0}..{X_MAX,0}, {X_MAX,1}..{X_MAX,Y_MAX}, then back to {0,0}.
//   clk_i         : clock, rising edge
//   rst_i         : synchronous active-high reset
//   pair_i        : upstream counter value {x[15:8], y[7:0]}
//   phase_o       : current tracker state
//   period_done_o : one-cycle pulse for each completed period
//   period_len_o  : length in cycles of the last completed period
//   period_cnt_o  : completed periods since reset, saturating at 255
//   err_o         : sticky sequence-violation flag
// ---------------------------------------------------------------------------
module counter_phase_tracker
    import counter_phase_tracker_pkg::*;
#(
    parameter int unsigned X_MAX = DEF_X_MAX,
    parameter int unsigned Y_MAX = DEF_Y_MAX
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] pair_i,
    output logic [2:0]  phase_o,
    output logic        period_done_o,
    output logic [7:0]  period_len_o,
    output logic [7:0]  period_cnt_o,
    output logic        err_o
);

    localparam logic [7:0] XM = 8'(X_MAX);
    localparam logic [7:0] YM = 8'(Y_MAX);

    phase_t      state_q, state_d;
    logic [15:0] exp_q, exp_d;
    logic [7:0]  cyc_q, cyc_d;
    logic [7:0]  len_q, len_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        period_inc;
    logic [7:0]  exp_x, exp_y;

    assign exp_x = exp_q[15:8];
    assign exp_y = exp_q[7:0];

    // Next-state logic. Every state compares the full 16-bit input against
    // the expected value; a mismatch while tracking falls into ERROR, which
    // only reset can leave. In IDLE anything but {0,0} is ignored so the
    // tracker can attach to a counter that is already running.
    always_comb begin
        state_d    = state_q;
        exp_d      = exp_q;
        cyc_d      = cyc_q;
        len_d      = len_q;
        done_d     = 1'b0;
        err_d      = err_q;
        period_inc = 1'b0;

        case (state_q)
            IDLE: begin
                if (pair_i == 16'h0000) begin
                    state_d = X_RAMP;
                    exp_d   = {8'd1, 8'd0};
                    cyc_d   = 8'd1;
                end
            end

            X_RAMP: begin
                if (pair_i != exp_q) begin
                    state_d = ERROR;
                    err_d   = 1'b1;
                end else begin
                    cyc_d = cyc_q + 8'd1;
                    if (exp_x == XM) begin
                        state_d = Y_RAMP;
                        exp_d   = {XM, 8'd1};
                    end else begin
                        exp_d = {exp_x + 8'd1, 8'd0};
                    end
                end
            end

            Y_RAMP: begin
                if (pair_i != exp_q) begin
                    state_d = ERROR;
                    err_d   = 1'b1;
                end else begin
                    cyc_d = cyc_q + 8'd1;
                    if (exp_y == YM) begin
                        state_d = WRAP;
                        exp_d   = 16'h0000;
                    end else begin
                        exp_d = {XM, exp_y + 8'd1};
                    end
                end
            end

            // The {0,0} that closes a period is also the first sample of the
            // next one, so the cycle counter restarts at 1 rather than 0.
            WRAP: begin
                if (pair_i == 16'h0000) begin
                    state_d    = X_RAMP;
                    exp_d      = {8'd1, 8'd0};
                    len_d      = cyc_q;
                    done_d     = 1'b1;
                    period_inc = 1'b1;
                    cyc_d      = 8'd1;
                end else begin
                    state_d = ERROR;
                    err_d   = 1'b1;
                end
            end

            ERROR: begin
                err_d = 1'b1;
            end

            default: begin
                state_d = ERROR;
                err_d   = 1'b1;
            end
        endcase
    end

    // State and output registers; reset returns everything to its idle
    // value regardless of where the tracker was.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            exp_q   <= 16'h0000;
            cyc_q   <= 8'd0;
            len_q   <= 8'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            cyc_q   <= cyc_d;
            len_q   <= len_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Completed-period count, cleared by the same reset as the FSM.
    sat_counter8 u_period_cnt (
        .clk   (clk_i),
        .clr   (rst_i),
        .inc   (period_inc),
        .count (period_cnt_o)
    );

    assign phase_o       = state_q;
    assign period_done_o = done_q;
    assign period_len_o  = len_q;
    assign err_o         = err_q;

endmodule

// File: doc/counter_phase_tracker.md
COUNTER_PHASE_TRACKER -- requirements
Module: counter_phase_tracker

Interface
REQ-001 Parameter X_MAX, 8, value at which x stops ramping; SHALL be 1..254.
REQ-002 Parameter Y_MAX, 6, final y value of a period; SHALL be 1..254, with X_MAX+Y_MAX+1 <= 255.
REQ-003 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous and active-high.
REQ-005 pair_i  input  16  upstream counter output, {x[15:8], y[7:0]}, sampled every cycle.
REQ-006 phase_o  output  3  current tracker state (encoding per REQ-024).
REQ-007 period_done_o  output  1  one-cycle pulse per completed, well-formed period.
REQ-008 period_len_o  output  8  cycle length of the last completed period; held between periods.
REQ-009 period_cnt_o  output  8  completed periods since reset, saturating at 255.
REQ-010 err_o  output  1  sticky sequence-violation flag.

Function
REQ-011 States: IDLE, X_RAMP, Y_RAMP, WRAP, ERROR; internal expected value exp = {exp_x, exp_y}; 8-bit cycle counter cyc.
REQ-012 IDLE: pair_i == {0,0} -> X_RAMP, exp={1,0}, cyc=1; any other value -> stay IDLE, no error (mid-stream attach).
REQ-013 X_RAMP: pair_i != exp -> ERROR; else cyc+=1; if exp_x == X_MAX -> Y_RAMP, exp={X_MAX,1}; else exp={exp_x+1,0}.
REQ-014 Y_RAMP: pair_i != exp -> ERROR; else cyc+=1; if exp_y == Y_MAX -> WRAP, exp={0,0}; else exp={X_MAX,exp_y+1}.
REQ-015 WRAP: pair_i == {0,0} -> X_RAMP, exp={1,0}, period_len_o=cyc, period_cnt_o+=1 (saturating), period_done_o=1 next cycle, cyc=1; else ERROR.
REQ-016 ERROR: absorbing until rst_i; err_o=1; period_cnt_o and period_len_o frozen.
REQ-017 All outputs SHALL be registered: an input sampled at edge N affects outputs visible after edge N+1 (latency 1 cycle).
REQ-018 period_done_o SHALL be high for exactly one cycle per accepted WRAP; never in IDLE or ERROR.
REQ-019 With defaults, a well-formed period SHALL report period_len_o = 15 (X_MAX+Y_MAX+1).
REQ-020 period_cnt_o at 255 SHALL stay 255 on further completions; period_done_o still pulses.
REQ-021 Comparisons SHALL use all 8 bits of x and y; exp arithmetic SHALL be 8-bit, never wrapping under legal parameters.

Reset
REQ-022 rst_i high at an edge SHALL force: state IDLE, phase_o=IDLE, period_done_o=0, period_len_o=0, period_cnt_o=0, err_o=0, cyc=0, exp={0,0}.
REQ-023 rst_i SHALL dominate every transition, including mid-period, in WRAP, and in ERROR; tracking resumes from IDLE rules the cycle after rst_i falls.

Structure
REQ-024 Shared package SHALL hold the phase enum (IDLE=0, X_RAMP=1, Y_RAMP=2, WRAP=3, ERROR=4) and default constants X_MAX=8, Y_MAX=6, shared with the upstream counter's bench.
REQ-025 One sub-module, sat_counter8 (8-bit increment-enable, saturating at 255, synchronous clear), SHALL implement period_cnt_o.
REQ-026 FSM, exp/cyc registers and output registers SHALL reside in counter_phase_tracker; no other hierarchy.

Verification
REQ-027 Drive from the real e_counter, release rst after 1 cycle -> period_done_o pulses every 15 cycles, period_len_o=15, period_cnt_o=1,2,3 after three periods, err_o=0.
REQ-028 Hold pair_i={5,3} then start a legal sequence at {0,0} -> phase_o stays IDLE, err_o=0 until {0,0}, then X_RAMP; first period counted normally.
REQ-029 Legal sequence to {4,0}, then inject {6,0} -> phase_o=ERROR and err_o=1 one cycle later; further legal periods leave period_cnt_o unchanged.
REQ-030 Legal sequence to {8,6}, then {8,7} instead of {0,0} -> ERROR, no period_done_o pulse.
REQ-031 Assert rst_i for one cycle at {8,3} while in Y_RAMP -> all outputs at reset values next cycle; subsequent legal period yields period_len_o=15, period_cnt_o=1.
REQ-032 Force 260 legal periods -> period_cnt_o saturates at 255, period_done_o still pulses each period.
